// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Assembles a little-endian byte stream (2-byte length header followed by
// program words) into 32-bit word writes, holding the CPU in reset while a
// load is in progress.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte, verified in the CHK state before DONE.

module imem_loader #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR, CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
    } state_t;
`endif

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [31:0]        word;
    logic [CNT_W-1:0]   len_full;
    logic               last_word;
    logic               xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         xsum;
`endif

    // Full header value as it will be once the high byte lands this cycle.
    assign len_full  = CNT_W'({byte_data, len[7:0]});
    assign last_word = (word_idx == len - CNT_W'(1));
    assign xfer      = byte_valid && byte_ready;

    // Write port mirrors the current word slot; only meaningful while wr_en is high.
    assign wr_addr = 32'(word_idx) << 2;
    assign wr_data = word;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        next_state = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (byte_valid) next_state = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (len_full == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = CHK;
`else
                        next_state = DONE;
`endif
                    else if (len_full > CNT_W'(DEPTH))
                        next_state = ERR;
                    else
                        next_state = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = DONE;
`endif
                else
                    next_state = DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (byte_valid) next_state = (byte_data == xsum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) next_state = LEN_LO;
            end
            ERR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
                if (start) next_state = LEN_LO;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: header capture, word assembly, word/byte indices, checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (start) xsum <= '0;
`endif
                end
                LEN_LO: begin
                    if (xfer) len[7:0] <= byte_data;
                end
                LEN_HI: begin
                    if (xfer) begin
                        len      <= len_full;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum <= xsum ^ byte_data;
`endif
                    end
                end
                WRITE: begin
                    byte_idx <= '0;
                    if (!last_word) word_idx <= word_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven per-cycle vectors plus
// a hand-written reset/idle sequence. Works with or without
// IMEM_LOADER_CHECKSUM_EN defined.

module tb_imem_loader;

    typedef enum {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} st_e;

    typedef struct {
        bit          rst;
        bit          start;
        bit          valid;
        logic [7:0]  data;
        st_e         st;     // state the DUT is expected to be in during this cycle
        logic [31:0] addr;   // expected wr_addr when st == S_WRITE
        logic [31:0] wdata;  // expected wr_data when st == S_WRITE
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {byte_ready, wr_en, cpu_hold, busy, done, err} per state.
    function automatic logic [5:0] flags_of(input st_e s);
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: return 6'b101100;
            S_WRITE:                           return 6'b011100;
            S_DONE:                            return 6'b000010;
            S_ERR:                             return 6'b001001;
            default:                           return 6'b000000;
        endcase
    endfunction

    task automatic push(input bit rst, input bit st_pulse, input bit valid, input logic [7:0] d,
                        input st_e s, input logic [31:0] a, input logic [31:0] wd);
        vec_t v;
        v.rst = rst; v.start = st_pulse; v.valid = valid; v.data = d;
        v.st = s; v.addr = a; v.wdata = wd;
        vecs.push_back(v);
    endtask

    // Two-word program load: header 02 00, words 0x00A00093 and 0x01400113.
    // With gap set, byte_valid toggles and the first byte of word 1 is
    // already offered during the first WRITE cycle.
    task automatic add_load(input st_e first, input bit gap);
        logic [31:0] words [2];
        logic [7:0]  d;
        logic [7:0]  xs;
        words[0] = 32'h00A00093;
        words[1] = 32'h01400113;
        xs = 8'h00;
        push(0, 1, 0, 8'h00, first, 0, 0);
        push(0, 0, 1, 8'h02, S_LEN_LO, 0, 0);
        if (gap) push(0, 0, 0, 8'h00, S_LEN_HI, 0, 0);
        push(0, 0, 1, 8'h00, S_LEN_HI, 0, 0);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                d = words[w][8*b +: 8];
                xs = xs ^ d;
                if (gap && !(w > 0 && b == 0)) push(0, 0, 0, 8'h00, S_DATA, 0, 0);
                push(0, 0, 1, d, S_DATA, 0, 0);
            end
            if (gap && w < 1)
                push(0, 0, 1, words[w+1][7:0], S_WRITE, 32'(w * 4), words[w]);
            else
                push(0, 0, 0, 8'h00, S_WRITE, 32'(w * 4), words[w]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(0, 0, 1, xs, S_CHK, 0, 0);
`endif
        push(0, 0, 0, 8'h00, S_DONE, 0, 0);
    endtask

    initial begin
        logic [5:0] act_flags;

        // Hand-written: reset held two cycles, then idle with byte_valid but no start.
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_flags", 64'({byte_ready, wr_en, cpu_hold, busy, done, err}), 64'(0));
        check("reset_wr_addr", 64'(wr_addr), 64'(0));
        check("reset_wr_data", 64'(wr_data), 64'(0));
        reset = 1'b0; byte_valid = 1'b1; byte_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle_nostart%0d", i),
                  64'({byte_ready, wr_en, cpu_hold, busy, done, err}), 64'(0));
        end
        byte_valid = 1'b0;

        // Back-to-back load from IDLE.
        add_load(S_IDLE, 0);
        // Same stream with gaps and a byte offered during WRITE, from DONE.
        add_load(S_DONE, 1);
        // Oversized header 0x0011 -> ERR; bytes ignored there; then recover.
        push(0, 1, 0, 8'h00, S_DONE, 0, 0);
        push(0, 0, 1, 8'h11, S_LEN_LO, 0, 0);
        push(0, 0, 1, 8'h00, S_LEN_HI, 0, 0);
        push(0, 0, 1, 8'h55, S_ERR, 0, 0);
        push(0, 0, 0, 8'h00, S_ERR, 0, 0);
        add_load(S_ERR, 0);
        // Zero-length header.
        push(0, 1, 0, 8'h00, S_DONE, 0, 0);
        push(0, 0, 1, 8'h00, S_LEN_LO, 0, 0);
        push(0, 0, 1, 8'h00, S_LEN_HI, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(0, 0, 1, 8'h00, S_CHK, 0, 0);
`endif
        push(0, 0, 0, 8'h00, S_DONE, 0, 0);
        // len == DEPTH accepted; start while busy ignored; reset mid-word aborts.
        push(0, 1, 0, 8'h00, S_DONE, 0, 0);
        push(0, 0, 1, 8'h10, S_LEN_LO, 0, 0);
        push(0, 0, 1, 8'h00, S_LEN_HI, 0, 0);
        push(0, 0, 1, 8'h11, S_DATA, 0, 0);
        push(0, 0, 1, 8'h22, S_DATA, 0, 0);
        push(0, 0, 1, 8'h33, S_DATA, 0, 0);
        push(0, 0, 1, 8'h44, S_DATA, 0, 0);
        push(0, 0, 0, 8'h00, S_WRITE, 32'h0, 32'h44332211);
        push(0, 1, 1, 8'hAA, S_DATA, 0, 0);
        push(0, 0, 1, 8'hBB, S_DATA, 0, 0);
        push(1, 0, 1, 8'hCC, S_DATA, 0, 0);
        push(0, 0, 1, 8'hDD, S_IDLE, 0, 0);
        push(0, 0, 0, 8'h00, S_IDLE, 0, 0);
        add_load(S_IDLE, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            start      = vecs[i].start;
            byte_valid = vecs[i].valid;
            byte_data  = vecs[i].data;
            #1;
            act_flags = {byte_ready, wr_en, cpu_hold, busy, done, err};
            check($sformatf("vec%0d_flags", i), 64'(act_flags), 64'(flags_of(vecs[i].st)));
            if (vecs[i].st == S_WRITE) begin
                check($sformatf("vec%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].addr));
                check($sformatf("vec%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].wdata));
            end
        end

        @(negedge clk);
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
